rv_decode_stage: RTL
====================

// Module: rv_decode_stage
// PURPOSE
//  Registered RV32I(+M) decode stage between fetch and execute. Accepts {instr, pc, tag} over
//  valid/ready, decodes to the team control bundle, holds results in a 2-entry skid buffer so
//  in_ready is a pure register output. Adds M-extension decode, illegal-instruction flagging,
//  flush, and a 32-bit decode performance counter.
// PARAMETERS
//  PC_W    32  width of pc passthrough
//  TAG_W   4   width of opaque tag passthrough
//  EN_M    0   1: decode RV32M (opcode 0110011, funct7 01); 0: those encodings are illegal
//  ALU_W   5   ALUControl width; >=5 required when EN_M=1
// PORTS
//  CLK         in   1      clock, rising edge
//  RESETn      in   1      asynchronous active-low reset
//  flush       in   1      drop all buffered and incoming entries this cycle
//  in_valid    in   1      fetch entry valid
//  in_ready    out  1      stage can accept (registered)
//  in_instr    in   32     instruction word
//  in_pc       in   PC_W   instruction pc
//  in_tag      in   TAG_W  opaque tag
//  out_valid   out  1      decoded entry valid
//  out_ready   in   1      execute accepts
//  out_pc/out_tag/out_instr  out  PC_W/TAG_W/32  passthrough of accepted entry
//  out_ctrl    out  CTRL_W packed rv_ctrl_t {RegW,MemW,MemtoReg,ALUSrc,ALUSrc_A,PC_4,Branch,
//                          PCS_dire,Imm,ImmSrc[3:0],Load_size[1:0],ALUControl[ALU_W-1:0]}
//  out_illegal out  1      entry's instruction is undefined; out_ctrl forced to NOP
//  decode_cnt  out  32     entries handed to execute since reset
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, out_ctrl=NOP (all zero), out_illegal=0, decode_cnt=0,
//   out_pc/out_tag/out_instr=0. Buffer state EMPTY.
//  Transfers: in-fire = in_valid&in_ready; out-fire = out_valid&out_ready. out_* stable while
//   out_valid&!out_ready. Latency in-fire -> out_valid = 1 cycle when EMPTY.
//  Skid FSM (count of held entries): EMPTY(0) -> ONE on in-fire. ONE: in-fire&out-fire stays
//   ONE (new entry becomes head); in-fire only -> FULL (second into skid slot); out-fire only
//   -> EMPTY. FULL: in_ready=0; out-fire -> ONE, skid slot promoted to head same edge.
//   in_ready next = (next state != FULL). No combinational path in_valid->in_ready or
//   out_ready->in_ready.
//  Decode is combinational on in_instr; result registered with the entry (no decode on output).
//  Control encoding: ALUControl 0 add,1 sub,2 xor,3 or,4 and,5 sll,6 srl,7 sra,8 slt,9 sltu,
//   10 lui,11 auipc; EN_M: 16 mul,17 mulh,18 mulhsu,19 mulhu,20 div,21 divu,22 rem,23 remu.
//   ImmSrc[2:0] R0 I1 S2 B3 U4 J5; ImmSrc[3]=unsigned (sltu/sltiu/lbu/lhu/bltu/bgeu).
//   Load_size 0 word, 1 half, 2 byte. Stores use S-type (2), not I-type.
//  Illegal: unknown opcode; R-type funct7 not 00/20 (01 if EN_M); funct7=20 with funct3 not 0/5;
//   shift-imm with bad imm[11:5]; load funct3 3/6/7; store funct3>2; branch funct3 2/3;
//   jalr funct3!=0. Illegal -> out_ctrl NOP (RegW=MemW=Branch=0), out_illegal=1, still passed.
//  flush: synchronous; next state EMPTY, out_valid=0, in_ready=1, incoming entry that cycle
//   discarded regardless of in_valid; an out-fire in the flush cycle still counts.
//  decode_cnt: +1 per out-fire, wraps 0xFFFFFFFF -> 0.
//  Async reset mid-transfer: all entries dropped immediately; no partial output.
// STRUCTURE
//  Package rv_pkg: opcode constants, ALU op enum, imm-type enum, load-size enum, rv_ctrl_t
//   struct, CTRL_W, CTRL_NOP.
//  Sub-module rv_decode_comb (pure combinational instr -> {ctrl, illegal}, EN_M param);
//   skid FSM, buffers and counter live in rv_decode_stage.
// TESTING
//  1 add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, ALUControl=0, RegW=1,
//    ImmSrc=0, out_illegal=0, decode_cnt=1.
//  2 stream 3 instrs, out_ready=0 -> in_ready drops after 2nd accept; 3rd held at input; raise
//    out_ready -> order preserved, tags 0,1,2, no loss/duplication.
//  3 0x0220C1B3 (div) EN_M=1 -> ALUControl=20; EN_M=0 -> out_illegal=1, RegW=0.
//  4 lbu (funct3 4) -> Load_size=2, ImmSrc=4'b1001; sb (0x00208023) -> MemW=1, ImmSrc[2:0]=2.
//  5 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed
//    entries never appear.
//  6 preload decode_cnt 0xFFFFFFFF (force) + one out-fire -> 0; RESETn low mid-stall -> all
//    outputs at reset values asynchronously.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared opcodes, decode enums and the packed control bundle for the decode stage
package rv_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam int ALU_BITS = 5;
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_XOR = 5'd2, ALU_OR = 5'd3, ALU_AND = 5'd4,
    ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7, ALU_SLT = 5'd8, ALU_SLTU = 5'd9,
    ALU_LUI = 5'd10, ALU_AUIPC = 5'd11
  } alu_op_e;
  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef enum logic [1:0] {LS_WORD, LS_HALF, LS_BYTE} load_size_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_e;
  typedef struct packed {
    logic reg_w;
    logic mem_w;
    logic mem_to_reg;
    logic alu_src;
    logic alu_src_a;
    logic pc_4;
    logic branch;
    logic pcs_dire;
    logic imm;
    logic [3:0] imm_src;
    logic [1:0] load_size;
    logic [ALU_BITS-1:0] alu_ctrl;
  } rv_ctrl_t;
  localparam int CTRL_W = $bits(rv_ctrl_t);
  localparam rv_ctrl_t CTRL_NOP = '0;
  function automatic logic [4:0] alu_of_f3(input logic [2:0] f3);
    case (f3)
      3'd0: return ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [1:0] size_of_f3(input logic [1:0] f3);
    return f3 == 2'd0 ? LS_BYTE : f3 == 2'd1 ? LS_HALF : LS_WORD;
  endfunction
endpackage

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: combinational RV32I(+M) instruction decode to control bundle and illegal flag
module rv_decode_comb
  import rv_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0] instr,
  output rv_ctrl_t    ctrl,
  output logic        illegal
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic unused;
  rv_ctrl_t c;
  logic bad;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused = ^{instr[24:15], instr[11:7]};
  // decode opcode/funct fields; any undefined encoding raises bad
  always_comb begin
    c = CTRL_NOP;
    bad = 1'b0;
    case (op)
      OP_LUI: begin
        c.reg_w = 1'b1; c.alu_src = 1'b1; c.imm = 1'b1;
        c.imm_src = {1'b0, IMM_U}; c.alu_ctrl = ALU_LUI;
      end
      OP_AUIPC: begin
        c.reg_w = 1'b1; c.alu_src = 1'b1; c.alu_src_a = 1'b1; c.imm = 1'b1;
        c.imm_src = {1'b0, IMM_U}; c.alu_ctrl = ALU_AUIPC;
      end
      OP_JAL: begin
        c.reg_w = 1'b1; c.alu_src = 1'b1; c.alu_src_a = 1'b1; c.pc_4 = 1'b1;
        c.pcs_dire = 1'b1; c.imm = 1'b1; c.imm_src = {1'b0, IMM_J};
      end
      OP_JALR: begin
        c.reg_w = 1'b1; c.alu_src = 1'b1; c.pc_4 = 1'b1; c.pcs_dire = 1'b1;
        c.imm = 1'b1; c.imm_src = {1'b0, IMM_I};
        bad = f3 != 3'd0;
      end
      OP_BRANCH: begin
        c.branch = 1'b1; c.imm = 1'b1; c.imm_src = {f3[1], IMM_B};
        c.alu_ctrl = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        bad = f3[2:1] == 2'b01;
      end
      OP_LOAD: begin
        c.reg_w = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; c.imm = 1'b1;
        c.imm_src = {f3[2], IMM_I}; c.load_size = size_of_f3(f3[1:0]);
        bad = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        c.mem_w = 1'b1; c.alu_src = 1'b1; c.imm = 1'b1;
        c.imm_src = {1'b0, IMM_S}; c.load_size = size_of_f3(f3[1:0]);
        bad = f3 > 3'd2;
      end
      OP_IMM: begin
        c.reg_w = 1'b1; c.alu_src = 1'b1; c.imm = 1'b1;
        c.imm_src = {f3 == 3'd3, IMM_I};
        c.alu_ctrl = (f3 == 3'd5 && f7[5]) ? ALU_SRA : alu_of_f3(f3);
        bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_REG: begin
        c.reg_w = 1'b1;
        c.imm_src = {f3 == 3'd3 && f7 == 7'h00, IMM_R};
        c.alu_ctrl = f7 == 7'h01 ? {2'b10, f3} : f7[5] ? (f3 == 3'd0 ? ALU_SUB : ALU_SRA) : alu_of_f3(f3);
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (EN_M && f7 == 7'h01));
      end
      default: bad = 1'b1;
    endcase
  end
  assign ctrl = bad ? CTRL_NOP : c;
  assign illegal = bad;
endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered decode stage with 2-entry skid buffer, flush and decode counter
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int TAG_W = 4,
  parameter bit EN_M  = 1'b0,
  parameter int ALU_W = 5
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [TAG_W-1:0]       out_tag,
  output logic [31:0]            out_instr,
  output logic [CTRL_W-ALU_BITS+ALU_W-1:0] out_ctrl,
  output logic                   out_illegal,
  output logic [31:0]            decode_cnt
);
  typedef struct packed {
    logic [31:0]      instr;
    logic [PC_W-1:0]  pc;
    logic [TAG_W-1:0] tag;
    rv_ctrl_t         ctrl;
    logic             ill;
  } entry_t;
  skid_e st_q, st_d;
  entry_t head_q, skid_q, in_e;
  rv_ctrl_t dec_ctrl;
  logic dec_ill, in_fire, out_fire;
  logic [31:0] cnt_q;
  rv_decode_comb #(.EN_M(EN_M)) u_dec (.instr(in_instr), .ctrl(dec_ctrl), .illegal(dec_ill));
  assign in_e = '{instr: in_instr, pc: in_pc, tag: in_tag, ctrl: dec_ctrl, ill: dec_ill};
  assign in_fire = in_valid && in_ready && !flush;
  assign out_fire = out_valid && out_ready;
  // skid state and registered in_ready
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      st_q <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      st_q <= st_d;
      in_ready <= st_d != FULL;
    end
  // occupancy transitions; flush empties regardless of traffic
  always_comb
    st_d = flush ? EMPTY :
           st_q == EMPTY ? (in_fire ? ONE : EMPTY) :
           st_q == ONE ? (in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : ONE) :
           (out_fire ? ONE : FULL);
  // outputs come straight from the head register
  always_comb begin
    out_valid = st_q != EMPTY;
    out_pc = head_q.pc;
    out_tag = head_q.tag;
    out_instr = head_q.instr;
    out_ctrl = {head_q.ctrl[CTRL_W-1:ALU_BITS], ALU_W'(head_q.ctrl.alu_ctrl)};
    out_illegal = head_q.ill;
    decode_cnt = cnt_q;
  end
  // head takes the new entry when it frees up, otherwise the skid slot catches it
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (in_fire && (st_q == EMPTY || out_fire)) head_q <= in_e;
      else if (st_q == FULL && out_fire) head_q <= skid_q;
      if (in_fire && st_q == ONE && !out_fire) skid_q <= in_e;
    end
  // count entries handed to execute
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) cnt_q <= '0;
    else cnt_q <= cnt_q + 32'(out_fire);
endmodule
